// File: rtl/bft_leaf_retry_bank.sv
// Leaf-side adapter between NUM_CH PEs and one BFT subtree switch.
// Per-channel retry FIFO, receive register and saturating resend counter.
module bft_leaf_retry_bank #(
    parameter int NUM_CH     = 8,
    parameter int payload_sz = 43,
    parameter int addr_sz    = 5,
    parameter int p_sz       = 1 + addr_sz + payload_sz,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          pe_valid,
    output logic [NUM_CH-1:0]          pe_ready,
    input  logic [NUM_CH*(p_sz-1)-1:0] pe_data,
    output logic [NUM_CH*p_sz-1:0]     tree_out,
    input  logic [NUM_CH-1:0]          resend,
    input  logic [NUM_CH*p_sz-1:0]     tree_in,
    output logic [NUM_CH-1:0]          rx_valid,
    output logic [NUM_CH*(p_sz-1)-1:0] rx_data,
    input  logic [NUM_CH-1:0]          rx_ready,
    output logic [NUM_CH-1:0]          rx_overflow,
    output logic [NUM_CH*CNT_W-1:0]    resend_cnt,
    input  logic                       clr_cnt
);

    localparam int DW = p_sz - 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]      FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]      CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CNT_W-1:0] RC_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RC_MAX   = '1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DW-1:0]    mem [FIFO_DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [PW:0]      count;
        logic             empty;
        logic             full;
        logic             push;
        logic             pop;
        logic             pkt_v;
        logic             loadable;
        logic             rv;
        logic [DW-1:0]    rd;
        logic             ovf;
        logic [CNT_W-1:0] rcnt;

        assign empty    = (count == '0);
        assign full     = (count == FULL_CNT);
        assign push     = pe_valid[c] & pe_ready[c];
        assign pop      = ~empty & ~resend[c];
        assign pkt_v    = tree_in[c*p_sz + p_sz - 1];
        assign loadable = ~rv | rx_ready[c];

        assign pe_ready[c]                = ~full & ~reset;
        assign tree_out[c*p_sz +: p_sz]   = empty ? '0 : {1'b1, mem[rd_ptr]};
        assign rx_valid[c]                = rv;
        assign rx_data[c*DW +: DW]        = rd;
        assign rx_overflow[c]             = ovf;
        assign resend_cnt[c*CNT_W +: CNT_W] = rcnt;

        // FIFO storage: written on push, needs no reset since empty masks it
        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr] <= pe_data[c*DW +: DW];
            end
        end

        // FIFO pointers and occupancy; head stays put while resend is high
        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end

        // Receive register with sticky drop flag
        always_ff @(posedge clk) begin
            if (reset) begin
                rv  <= 1'b0;
                rd  <= '0;
                ovf <= 1'b0;
            end else begin
                if (pkt_v) begin
                    if (loadable) begin
                        rd <= tree_in[c*p_sz +: DW];
                        rv <= 1'b1;
                    end
                end else if (rx_ready[c]) begin
                    rv <= 1'b0;
                end
                if (clr_cnt) begin
                    ovf <= 1'b0;
                end else if (pkt_v & ~loadable) begin
                    ovf <= 1'b1;
                end
            end
        end

        // Saturating count of rejected presentations
        always_ff @(posedge clk) begin
            if (reset || clr_cnt) begin
                rcnt <= '0;
            end else if (~empty && resend[c] && rcnt != RC_MAX) begin
                rcnt <= rcnt + RC_ONE;
            end
        end
    end

endmodule

// File: tb/tb_bft_leaf_retry_bank.sv
// Randomized bench for bft_leaf_retry_bank against a queue-based model.
// Directed phases pin the model with literal expectations.
module tb_bft_leaf_retry_bank;

    localparam int N  = 8;
    localparam int PL = 43;
    localparam int AW = 5;
    localparam int P  = 1 + AW + PL;
    localparam int DW = P - 1;
    localparam int D  = 4;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     pe_valid;
    logic [N-1:0]     pe_ready;
    logic [N*DW-1:0]  pe_data;
    logic [N*P-1:0]   tree_out;
    logic [N-1:0]     resend;
    logic [N*P-1:0]   tree_in;
    logic [N-1:0]     rx_valid;
    logic [N*DW-1:0]  rx_data;
    logic [N-1:0]     rx_ready;
    logic [N-1:0]     rx_overflow;
    logic [N*CW-1:0]  resend_cnt;
    logic             clr_cnt;

    always #5 clk = ~clk;

    bft_leaf_retry_bank #(
        .NUM_CH(N), .payload_sz(PL), .addr_sz(AW), .p_sz(P),
        .FIFO_DEPTH(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data),
        .tree_out(tree_out), .resend(resend), .tree_in(tree_in),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_overflow(rx_overflow), .resend_cnt(resend_cnt),
        .clr_cnt(clr_cnt)
    );

    // behavioural model
    logic [DW-1:0] mq [N][$];
    logic          m_rv  [N];
    logic [DW-1:0] m_rd  [N];
    logic          m_ovf [N];
    int            m_cnt [N];

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            int sz;
            bit pv;
            bit ld;
            sz = mq[c].size();
            pv = tree_in[c*P + P - 1];
            ld = !m_rv[c] || rx_ready[c];
            if (reset) begin
                mq[c].delete();
                m_rv[c]  = 0;
                m_rd[c]  = '0;
                m_ovf[c] = 0;
                m_cnt[c] = 0;
            end else begin
                if (sz > 0 && resend[c] && m_cnt[c] < (1 << CW) - 1)
                    m_cnt[c]++;
                if (sz > 0 && !resend[c])
                    void'(mq[c].pop_front());
                if (pe_valid[c] && sz < D)
                    mq[c].push_back(pe_data[c*DW +: DW]);
                if (pv) begin
                    if (ld) begin
                        m_rd[c] = tree_in[c*P +: DW];
                        m_rv[c] = 1;
                    end else begin
                        m_ovf[c] = 1;
                    end
                end else if (rx_ready[c]) begin
                    m_rv[c] = 0;
                end
                if (clr_cnt) begin
                    m_cnt[c] = 0;
                    m_ovf[c] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        vectors++;
        started = 1;
    endtask

    // compare every output against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            for (int c = 0; c < N; c++) begin
                logic [P-1:0] et;
                bit er;
                et = (mq[c].size() > 0) ? {1'b1, mq[c][0]} : '0;
                er = !reset && (mq[c].size() < D);
                chk($sformatf("tree_out ch%0d", c), 64'(tree_out[c*P +: P]), 64'(et));
                chk($sformatf("pe_ready ch%0d", c), 64'(pe_ready[c]), 64'(er));
                chk($sformatf("rx_valid ch%0d", c), 64'(rx_valid[c]), 64'(m_rv[c]));
                chk($sformatf("rx_data ch%0d", c), 64'(rx_data[c*DW +: DW]), 64'(m_rd[c]));
                chk($sformatf("rx_overflow ch%0d", c), 64'(rx_overflow[c]), 64'(m_ovf[c]));
                chk($sformatf("resend_cnt ch%0d", c), 64'(resend_cnt[c*CW +: CW]), 64'(m_cnt[c]));
            end
        end
    end

    task automatic rand_inputs();
        for (int c = 0; c < N; c++) begin
            pe_valid[c]          = $urandom_range(0, 3) != 0;
            pe_data[c*DW +: DW]  = DW'({$urandom(), $urandom()});
            resend[c]            = $urandom_range(0, 3) == 0;
            tree_in[c*P +: P]    = {1'($urandom_range(0, 1)), DW'({$urandom(), $urandom()})};
            rx_ready[c]          = $urandom_range(0, 2) != 0;
        end
        clr_cnt = $urandom_range(0, 63) == 0;
        reset   = $urandom_range(0, 149) == 0;
    endtask

    initial begin
        reset    = 1'b1;
        clr_cnt  = 1'b0;
        pe_valid = '0;
        pe_data  = '0;
        resend   = '0;
        tree_in  = '0;
        rx_ready = '0;

        // reset state
        step();
        step();
        chk("rst_ready", 64'(pe_ready), 64'h0);
        chk("rst_tree", 64'(|tree_out), 64'h0);
        chk("rst_rxv", 64'(rx_valid), 64'h0);
        chk("rst_cnt", 64'(|resend_cnt), 64'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 64'(pe_ready), 64'hFF);

        // ch0 streaming 1..4 with no resend
        for (int i = 1; i <= 4; i++) begin
            pe_valid[0]    = 1'b1;
            pe_data[0 +: DW] = DW'(i);
            step();
            chk($sformatf("ch0_stream%0d", i), 64'(tree_out[0 +: P]),
                64'({1'b1, DW'(i)}));
        end
        pe_valid[0] = 1'b0;
        step();
        chk("ch0_drained", 64'(tree_out[0 +: P]), 64'h0);

        // ch3 fill under resend
        resend[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pe_valid[3]         = 1'b1;
            pe_data[3*DW +: DW] = DW'(32'hA0 + i);
            step();
            chk("ch3_head_fill", 64'(tree_out[3*P +: P]), 64'({1'b1, DW'(32'hA0)}));
        end
        chk("ch3_full_ready", 64'(pe_ready[3]), 64'h0);
        pe_data[3*DW +: DW] = DW'(32'hB0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ch3_head_hold", 64'(tree_out[3*P +: P]), 64'({1'b1, DW'(32'hA0)}));
        end
        chk("ch3_resend_cnt", 64'(resend_cnt[3*CW +: CW]), 64'd6);

        // release resend on full ch3
        resend[3] = 1'b0;
        step();
        chk("ch3_ready_rise", 64'(pe_ready[3]), 64'h1);
        chk("ch3_next_head", 64'(tree_out[3*P +: P]), 64'({1'b1, DW'(32'hA1)}));
        for (int i = 1; i <= 3; i++) begin
            pe_data[3*DW +: DW] = DW'(32'hB0 + i);
            step();
        end
        pe_valid[3] = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // ch5 overflow
        for (int i = 0; i < 3; i++) begin
            tree_in[5*P +: P] = {1'b1, DW'(32'h100 + i)};
            step();
            chk("ch5_rx_valid", 64'(rx_valid[5]), 64'h1);
            chk("ch5_rx_held", 64'(rx_data[5*DW +: DW]), 64'h100);
            chk("ch5_ovf", 64'(rx_overflow[5]), 64'(i > 0));
        end
        tree_in = '0;
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("ch5_ovf_clr", 64'(rx_overflow[5]), 64'h0);
        rx_ready[5] = 1'b1;
        step();
        chk("ch5_rx_consumed", 64'(rx_valid[5]), 64'h0);
        rx_ready[5] = 1'b0;

        // ch1 counter saturation
        pe_valid[1]         = 1'b1;
        pe_data[1*DW +: DW] = DW'(32'h55);
        step();
        pe_valid[1] = 1'b0;
        resend[1]   = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("ch1_cnt_sat", 64'(resend_cnt[1*CW +: CW]), 64'd15);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("ch1_cnt_clr", 64'(resend_cnt[1*CW +: CW]), 64'd0);
        resend[1] = 1'b0;
        step();

        // randomized traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step();
        end

        // mid-stream reset on all channels
        rand_inputs();
        reset = 1'b0;
        step();
        rand_inputs();
        reset = 1'b1;
        step();
        chk("mid_rst_tree", 64'(|tree_out), 64'h0);
        chk("mid_rst_rxv", 64'(rx_valid), 64'h0);
        chk("mid_rst_cnt", 64'(|resend_cnt), 64'h0);
        reset    = 1'b0;
        pe_valid = '0;
        tree_in  = '0;
        clr_cnt  = 1'b0;
        step();
        chk("post_rst_tree", 64'(|tree_out), 64'h0);
        chk("post_rst_rxv", 64'(rx_valid), 64'h0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
